// File: rtl/btn_debounce_ctrl_pkg.sv
// btn_debounce_ctrl_pkg: channel FSM states and counter sizing shared by the debouncer
package btn_debounce_ctrl_pkg;
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // Width that holds the largest of the three tick thresholds.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction
endpackage

// File: rtl/btn_debounce_chan.sv
// btn_debounce_chan: one button filter with hold-to-repeat
//   clk, rst_n : clock, async active-low reset
//   s          : synchronised button, active-low
//   tick       : one-clk prescaler strobe
//   e_debug    : accept changes on the next clk, suppress repeat
//   level      : debounced level, active-low
//   press, rel : one-clk pulses on accepted press / release
//   rpt        : one-clk auto-repeat pulse while held
module btn_debounce_chan
   import btn_debounce_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_TICKS      = 1000,
   parameter int REPEAT_DELAY_TICKS  = 50000,
   parameter int REPEAT_PERIOD_TICKS = 10000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic s,
   input  logic tick,
   input  logic e_debug,
   output logic level,
   output logic press,
   output logic rel,
   output logic rpt
);
   localparam int CW = cnt_width(DEBOUNCE_TICKS, REPEAT_DELAY_TICKS, REPEAT_PERIOD_TICKS);
   localparam logic [CW-1:0] DB = CW'(DEBOUNCE_TICKS);
   localparam logic [CW-1:0] RD = CW'(REPEAT_DELAY_TICKS);
   localparam logic [CW-1:0] RP = CW'(REPEAT_PERIOD_TICKS);
   localparam bit RPT_EN = REPEAT_DELAY_TICKS != 0;

   btn_state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx, cnt_inc, target;
   logic armed, armed_nx, level_nx, press_nx, rel_nx, rpt_nx;

   assign cnt_inc = (tick && cnt != '1) ? cnt + CW'(1) : cnt;
   // armed: first repeat already issued, so later ones use the period
   assign target  = armed ? RP : RD;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt_inc;
      armed_nx = armed;
      level_nx = level;
      press_nx = 1'b0;
      rel_nx   = 1'b0;
      rpt_nx   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (!s) state_nx = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (s) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (e_debug || cnt == DB) begin
               state_nx = HELD;
               cnt_nx   = '0;
               armed_nx = 1'b0;
               press_nx = 1'b1;
               level_nx = 1'b0;
            end
         end
         HELD: begin
            if (s) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = '0;
            end else if (RPT_EN && cnt == target) begin
               cnt_nx   = '0;
               armed_nx = 1'b1;
               rpt_nx   = !e_debug;
            end
         end
         RELEASE_WAIT: begin
            if (!s) begin
               // bounce back to held: repeat timing restarts, no new press
               state_nx = HELD;
               cnt_nx   = '0;
               armed_nx = 1'b0;
            end else if (e_debug || cnt == DB) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               rel_nx   = 1'b1;
               level_nx = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         armed <= 1'b0;
         level <= 1'b1;
         press <= 1'b0;
         rel   <= 1'b0;
         rpt   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         armed <= armed_nx;
         level <= level_nx;
         press <= press_nx;
         rel   <= rel_nx;
         rpt   <= rpt_nx;
      end
   end
endmodule

// File: rtl/btn_debounce_ctrl.sv
// btn_debounce_ctrl: N-channel active-low push-button debouncer with shared tick prescaler
//   clk, rst_n   : clock, async active-low reset
//   e_debug      : bypass filtering, no repeat
//   btns_in      : raw buttons, active-low
//   btns_level   : debounced levels, active-low
//   btns_press   : one-clk pulses on accepted press
//   btns_release : one-clk pulses on accepted release
//   btns_rpt     : one-clk auto-repeat pulses while held
module btn_debounce_ctrl
   import btn_debounce_ctrl_pkg::*;
#(
   parameter int N_BUTTONS           = 3,
   parameter int CLKS_PER_TICK       = 250,
   parameter int DEBOUNCE_TICKS      = 1000,
   parameter int REPEAT_DELAY_TICKS  = 50000,
   parameter int REPEAT_PERIOD_TICKS = 10000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 e_debug,
   input  logic [N_BUTTONS-1:0] btns_in,
   output logic [N_BUTTONS-1:0] btns_level,
   output logic [N_BUTTONS-1:0] btns_press,
   output logic [N_BUTTONS-1:0] btns_release,
   output logic [N_BUTTONS-1:0] btns_rpt
);
   localparam int PSW = $clog2(CLKS_PER_TICK);

   logic [N_BUTTONS-1:0] s1, s2;
   logic [PSW-1:0] pcnt;
   logic tick;

   assign tick = pcnt == PSW'(CLKS_PER_TICK - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= '1;
         s2   <= '1;
         pcnt <= '0;
      end else begin
         s1   <= btns_in;
         s2   <= s1;
         pcnt <= tick ? '0 : pcnt + PSW'(1);
      end
   end

   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
      btn_debounce_chan #(
         .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
         .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
         .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .s       (s2[i]),
         .tick    (tick),
         .e_debug (e_debug),
         .level   (btns_level[i]),
         .press   (btns_press[i]),
         .rel     (btns_release[i]),
         .rpt     (btns_rpt[i])
      );
   end
endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// tb_btn_debounce_ctrl: directed and randomized checks of btn_debounce_ctrl against a level/tick model
module tb_btn_debounce_ctrl;
   localparam int N  = 3;
   localparam int C  = 4;
   localparam int D  = 3;
   localparam int RD = 5;
   localparam int RP = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic e_debug = 1'b0;
   logic [N-1:0] btns_in = '1;
   logic [N-1:0] btns_level, btns_press, btns_release, btns_rpt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   btn_debounce_ctrl #(
      .N_BUTTONS           (N),
      .CLKS_PER_TICK       (C),
      .DEBOUNCE_TICKS      (D),
      .REPEAT_DELAY_TICKS  (RD),
      .REPEAT_PERIOD_TICKS (RP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .e_debug      (e_debug),
      .btns_in      (btns_in),
      .btns_level   (btns_level),
      .btns_press   (btns_press),
      .btns_release (btns_release),
      .btns_rpt     (btns_rpt)
   );

   // Reference: each channel holds an accepted level and, while the synchronised
   // input disagrees with it, a count of ticks seen since the disagreement began.
   logic [N-1:0] m_s1 = '1, m_s2 = '1, m_lvl = '1, m_press = '0, m_rel = '0;
   logic [N-1:0] m_pend = '0;
   int m_n [N];
   int m_cyc = 0;

   initial begin
      bit tk;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_s1 = '1; m_s2 = '1; m_lvl = '1; m_press = '0; m_rel = '0; m_pend = '0; m_cyc = 0;
            for (int i = 0; i < N; i++) m_n[i] = 0;
         end else begin
            tk = (m_cyc % C) == C - 1;
            m_press = '0;
            m_rel = '0;
            for (int i = 0; i < N; i++) begin
               if (!m_pend[i]) begin
                  if (m_s2[i] != m_lvl[i]) begin
                     m_pend[i] = 1'b1;
                     m_n[i] = 0;
                  end
               end else if (m_s2[i] == m_lvl[i]) begin
                  m_pend[i] = 1'b0;
               end else if (e_debug || m_n[i] == D) begin
                  m_lvl[i] = m_s2[i];
                  m_pend[i] = 1'b0;
                  if (m_s2[i] == 1'b0) m_press[i] = 1'b1;
                  else m_rel[i] = 1'b1;
               end else if (tk) begin
                  m_n[i] = m_n[i] + 1;
               end
            end
            m_s2 = m_s1;
            m_s1 = btns_in;
            m_cyc = m_cyc + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0; btns_in = '1; e_debug = 1'b0;
      repeat (3) step();
      checks++;
      if (btns_level !== 3'b111 || btns_press !== 3'b000 || btns_release !== 3'b000 || btns_rpt !== 3'b000) begin
         errors++;
         $display("FAIL reset_state: level=%b press=%b release=%b rpt=%b, want 111/000/000/000",
                  btns_level, btns_press, btns_release, btns_rpt);
      end
      @(negedge clk) rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         step();
         if (btns_press !== '0 || btns_release !== '0 || btns_rpt !== '0 || btns_level !== '1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_exit_quiet: %0d bad cycles, want 0", bad);
      end
   endtask

   task automatic test_press();
      int lat, np, nr;
      logic [N-1:0] pv;
      lat = 0; np = 0; nr = 0; pv = '0;
      btns_in = 3'b110;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (btns_press !== '0) begin
            np++;
            if (lat == 0) begin lat = k; pv = btns_press; end
         end
         if (btns_release !== '0) nr++;
      end
      checks++;
      if (lat < 13 || lat > 16) begin
         errors++;
         $display("FAIL press_latency: got %0d clks, want 13..16", lat);
      end
      checks++;
      if (pv !== 3'b001) begin errors++; $display("FAIL press_value: got %b, want 001", pv); end
      checks++;
      if (np != 1) begin errors++; $display("FAIL press_count: got %0d, want 1", np); end
      checks++;
      if (nr != 0) begin errors++; $display("FAIL press_no_release: got %0d pulses, want 0", nr); end
      checks++;
      if (btns_level !== 3'b110) begin errors++; $display("FAIL press_level: got %b, want 110", btns_level); end
      btns_in = '1;
      repeat (30) step();
   endtask

   task automatic test_glitch();
      int np, bad;
      np = 0; bad = 0;
      btns_in = 3'b110;
      repeat (6) step();
      btns_in = 3'b111;
      repeat (30) begin
         step();
         if (btns_press !== '0) np++;
         if (btns_level !== 3'b111) bad++;
      end
      checks++;
      if (np != 0) begin errors++; $display("FAIL glitch_press: got %0d pulses, want 0", np); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL glitch_level: %0d cycles not 111, want 0", bad); end
   endtask

   task automatic test_repeat();
      int lat, nr, d;
      logic [N-1:0] pv, rv, exp;
      lat = 0; pv = '0;
      btns_in = 3'b101;
      for (int k = 1; k <= 200; k++) begin
         step();
         if (lat == 0 && btns_press !== '0) begin lat = k; pv = btns_press; end
         d = k - lat;
         exp = (lat != 0 && d >= RD * C && (d - RD * C) % (RP * C) == 0) ? 3'b010 : 3'b000;
         checks++;
         if (btns_rpt !== exp) begin
            errors++;
            $display("FAIL repeat_pulse: clk %0d after press got %b, want %b", d, btns_rpt, exp);
         end
      end
      checks++;
      if (lat < 13 || lat > 16 || pv !== 3'b010) begin
         errors++;
         $display("FAIL repeat_press: latency %0d value %b, want 13..16 / 010", lat, pv);
      end
      btns_in = 3'b111;
      lat = 0; nr = 0; rv = '0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (btns_release !== '0) begin
            nr++;
            if (lat == 0) begin lat = k; rv = btns_release; end
         end
      end
      checks++;
      if (lat < 13 || lat > 16 || rv !== 3'b010 || nr != 1) begin
         errors++;
         $display("FAIL repeat_release: latency %0d value %b count %0d, want 13..16 / 010 / 1", lat, rv, nr);
      end
   endtask

   task automatic test_debug();
      int lat, bad;
      logic [N-1:0] pv;
      lat = 0; bad = 0; pv = '0;
      e_debug = 1'b1;
      btns_in = 3'b011;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (lat == 0 && btns_press !== '0) begin lat = k; pv = btns_press; end
         if (btns_rpt !== '0) bad++;
      end
      checks++;
      if (lat != 4 || pv !== 3'b100) begin
         errors++;
         $display("FAIL debug_press: latency %0d value %b, want 4 / 100", lat, pv);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL debug_no_rpt: %0d rpt cycles, want 0", bad); end
      btns_in = 3'b111;
      lat = 0; pv = '0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (lat == 0 && btns_release !== '0) begin lat = k; pv = btns_release; end
      end
      checks++;
      if (lat != 4 || pv !== 3'b100) begin
         errors++;
         $display("FAIL debug_release: latency %0d value %b, want 4 / 100", lat, pv);
      end
      e_debug = 1'b0;
      repeat (5) step();
   endtask

   task automatic test_simultaneous();
      int lat;
      logic [N-1:0] pv, rv;
      lat = 0; pv = '0; rv = '0;
      btns_in = 3'b010;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (lat == 0 && btns_press !== '0) begin lat = k; pv = btns_press; end
      end
      checks++;
      if (lat < 13 || lat > 16 || pv !== 3'b101) begin
         errors++;
         $display("FAIL simul_press: latency %0d value %b, want 13..16 / 101", lat, pv);
      end
      btns_in = 3'b011;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (lat == 0 && btns_release !== '0) begin lat = k; rv = btns_release; end
      end
      checks++;
      if (lat < 13 || lat > 16 || rv !== 3'b001) begin
         errors++;
         $display("FAIL simul_release: latency %0d value %b, want 13..16 / 001", lat, rv);
      end
      checks++;
      if (btns_level !== 3'b011) begin errors++; $display("FAIL simul_level: got %b, want 011", btns_level); end
      btns_in = 3'b111;
      repeat (40) step();
   endtask

   task automatic test_random();
      int idx;
      for (int k = 0; k < 3000; k++) begin
         step();
         checks++;
         if (btns_level !== m_lvl) begin
            errors++;
            $display("FAIL rand_level: cycle %0d got %b, want %b", k, btns_level, m_lvl);
         end
         checks++;
         if (btns_press !== m_press) begin
            errors++;
            $display("FAIL rand_press: cycle %0d got %b, want %b", k, btns_press, m_press);
         end
         checks++;
         if (btns_release !== m_rel) begin
            errors++;
            $display("FAIL rand_release: cycle %0d got %b, want %b", k, btns_release, m_rel);
         end
         checks++;
         if ((btns_press & btns_release) !== '0) begin
            errors++;
            $display("FAIL rand_overlap: cycle %0d press %b release %b, want disjoint", k, btns_press, btns_release);
         end
         if ($urandom_range(0, 15) == 0) begin
            idx = $urandom_range(0, N - 1);
            btns_in[idx] = ~btns_in[idx];
         end
         if ($urandom_range(0, 199) == 0) e_debug = ~e_debug;
      end
      e_debug = 1'b0;
      btns_in = '1;
      repeat (40) step();
   endtask

   task automatic test_reset_mid();
      int bad;
      btns_in = 3'b101;
      repeat (30) step();
      checks++;
      if (btns_level !== 3'b101) begin errors++; $display("FAIL mid_held_level: got %b, want 101", btns_level); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (btns_level !== 3'b111 || btns_press !== '0 || btns_release !== '0 || btns_rpt !== '0) begin
         errors++;
         $display("FAIL mid_async_reset: level=%b press=%b release=%b rpt=%b, want 111/000/000/000",
                  btns_level, btns_press, btns_release, btns_rpt);
      end
      btns_in = 3'b111;
      repeat (3) step();
      @(negedge clk) rst_n = 1'b1;
      bad = 0;
      repeat (40) begin
         step();
         if (btns_press !== '0 || btns_release !== '0 || btns_rpt !== '0 || btns_level !== '1) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL mid_reset_exit: %0d bad cycles, want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_press();
      test_glitch();
      test_repeat();
      test_debug();
      test_simultaneous();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end
endmodule
